// File: rtl/ex_wb_pkg.sv
// ----------------------------------------------------------------------------
// ex_wb_pkg
// Shared definitions for the execute-to-writeback stage:
//   - KGP-RISC branch-op encodings (BR_NONE .. BR_NCY, BR_RSV)
//   - skid buffer FSM state encoding
//   - entry field widths and a helper that sizes the packed entry
// ----------------------------------------------------------------------------
package ex_wb_pkg;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_B    = 3'b001;
    localparam logic [2:0] BR_LTZ  = 3'b010;
    localparam logic [2:0] BR_Z    = 3'b011;
    localparam logic [2:0] BR_NZ   = 3'b100;
    localparam logic [2:0] BR_CY   = 3'b101;
    localparam logic [2:0] BR_NCY  = 3'b110;
    localparam logic [2:0] BR_RSV  = 3'b111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    // Single-bit entry fields: carry, reg_write, flag_update.
    localparam int CTRL_W = 3;

    // Packed entry = br_target + result + rd + br_op + control bits.
    function automatic int entry_width(int data_w, int addr_w, int br_w);
        return 2 * data_w + addr_w + br_w + CTRL_W;
    endfunction

endpackage

// File: rtl/skid_buffer_2.sv
// ----------------------------------------------------------------------------
// skid_buffer_2
// Generic 2-entry valid/ready buffer with synchronous flush.
// in_ready depends only on registered state, so there is no combinational
// path from out_ready back to in_ready.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 drop all buffered entries (and any same-cycle accept)
//   in_valid/in_ready     upstream handshake, in_data payload
//   out_valid/out_ready   downstream handshake, out_data = head payload
// ----------------------------------------------------------------------------
module skid_buffer_2
    import ex_wb_pkg::*;
#(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data
);

    skid_state_e          state_q, state_d;
    logic                 rst_done_q;
    logic [PAYLOAD_W-1:0] head_p1, tail_p1;
    logic                 accept, commit;
    logic                 head_load, head_from_tail, tail_load;

    // Holds in_ready low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_done_q <= 1'b0;
        else        rst_done_q <= 1'b1;
    end

    assign in_ready  = rst_done_q && (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = head_p1;
    assign accept    = in_valid && in_ready;
    assign commit    = out_valid && out_ready;

    always_comb begin
        state_d        = state_q;
        head_load      = 1'b0;
        head_from_tail = 1'b0;
        tail_load      = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d   = ST_ONE;
                    head_load = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && commit) begin
                    head_load = 1'b1;
                end else if (accept) begin
                    state_d   = ST_FULL;
                    tail_load = 1'b1;
                end else if (commit) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (commit) begin
                    state_d        = ST_ONE;
                    head_from_tail = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // A same-cycle commit has already been seen downstream; flush only
        // discards what remains and blocks the incoming entry.
        if (flush) begin
            state_d        = ST_EMPTY;
            head_load      = 1'b0;
            head_from_tail = 1'b0;
            tail_load      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    // ---- stage p1: buffered entries (head is presented downstream) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_p1 <= '0;
            tail_p1 <= '0;
        end else begin
            if (head_load)           head_p1 <= in_data;
            else if (head_from_tail) head_p1 <= tail_p1;
            if (tail_load)           tail_p1 <= in_data;
        end
    end

endmodule

// File: rtl/ex_wb_stage.sv
// ----------------------------------------------------------------------------
// ex_wb_stage
// Execute-to-writeback stage downstream of the ALU. Buffers ALU results in a
// 2-entry skid buffer, keeps the architectural flags (carry, zero, sign),
// drives register-file writeback and resolves KGP-RISC branches on the head.
//
// Optional feature (macro STALL_COUNT_EN): adds output stall_cycles, a
// saturating count of cycles with out_valid & !out_ready.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   in_valid/in_ready                  upstream handshake
//   alu_result, alu_carry, rd_addr,
//   reg_write, flag_update, br_op,
//   br_target                          entry payload from execute
//   flush                              discard buffered entries
//   out_valid/out_ready                head handshake
//   wb_en, wb_addr, wb_data            register-file writeback
//   br_taken, br_addr                  branch resolution of the head
//   flag_c, flag_z, flag_s             committed flags
//   stall_cycles                       (STALL_COUNT_EN only)
// ----------------------------------------------------------------------------
module ex_wb_stage
    import ex_wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BR_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              reg_write,
    input  logic              flag_update,
    input  logic [BR_W-1:0]   br_op,
    input  logic [DATA_W-1:0] br_target,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              br_taken,
    output logic [DATA_W-1:0] br_addr,
    output logic              flag_c,
    output logic              flag_z,
    output logic              flag_s
`ifdef STALL_COUNT_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    localparam int ENTRY_W = entry_width(DATA_W, ADDR_W, BR_W);

    logic [ENTRY_W-1:0] entry_p0, head_p1;
    logic [DATA_W-1:0]  target_p1, result_p1;
    logic [ADDR_W-1:0]  rd_p1;
    logic [BR_W-1:0]    br_op_p1;
    logic               carry_p1, reg_write_p1, flag_update_p1;
    logic               commit;

    // Branch condition of the head; carry conditions use committed flags.
    function automatic logic resolve_branch(logic [BR_W-1:0]   op,
                                            logic [DATA_W-1:0] res,
                                            logic              cflag);
        logic taken;
        taken = 1'b0;
        case (op)
            BR_W'(BR_B):    taken = 1'b1;
            BR_W'(BR_LTZ):  taken = res[DATA_W-1];
            BR_W'(BR_Z):    taken = (res == '0);
            BR_W'(BR_NZ):   taken = (res != '0);
            BR_W'(BR_CY):   taken = cflag;
            BR_W'(BR_NCY):  taken = !cflag;
            BR_W'(BR_NONE),
            BR_W'(BR_RSV):  taken = 1'b0;
            default:        taken = 1'b0;
        endcase
        return taken;
    endfunction

    // ---- stage p0: pack the incoming ALU entry ----
    assign entry_p0 = {br_target, alu_result, rd_addr, br_op,
                       alu_carry, reg_write, flag_update};

    skid_buffer_2 #(
        .PAYLOAD_W (ENTRY_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (entry_p0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head_p1)
    );

    // ---- stage p1: head entry, writeback, branch and flag commit ----
    assign {target_p1, result_p1, rd_p1, br_op_p1,
            carry_p1, reg_write_p1, flag_update_p1} = head_p1;

    assign commit   = out_valid && out_ready;
    assign wb_en    = out_valid && reg_write_p1;
    assign wb_addr  = rd_p1;
    assign wb_data  = result_p1;
    assign br_addr  = target_p1;
    assign br_taken = out_valid && resolve_branch(br_op_p1, result_p1, flag_c);

    // Flags are touched only by commits; flush leaves them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_c <= 1'b0;
            flag_z <= 1'b0;
            flag_s <= 1'b0;
        end else if (commit && flag_update_p1) begin
            flag_c <= carry_p1;
            flag_z <= (result_p1 == '0);
            flag_s <= result_p1[DATA_W-1];
        end
    end

`ifdef STALL_COUNT_EN
    function automatic logic [31:0] sat_inc(logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       stall_cycles <= '0;
        else if (out_valid && !out_ready) stall_cycles <= sat_inc(stall_cycles);
    end
`endif

endmodule

// File: tb/tb_ex_wb_stage.sv
module tb_ex_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic        alu_carry;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        flag_update;
    logic [2:0]  br_op;
    logic [31:0] br_target;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        br_taken;
    logic [31:0] br_addr;
    logic        flag_c, flag_z, flag_s;
`ifdef STALL_COUNT_EN
    logic [31:0] stall_cycles;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        we;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    ex_wb_stage #(
        .DATA_W (32),
        .ADDR_W (5),
        .BR_W   (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_result   (alu_result),
        .alu_carry    (alu_carry),
        .rd_addr      (rd_addr),
        .reg_write    (reg_write),
        .flag_update  (flag_update),
        .br_op        (br_op),
        .br_target    (br_target),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .br_taken     (br_taken),
        .br_addr      (br_addr),
        .flag_c       (flag_c),
        .flag_z       (flag_z),
        .flag_s       (flag_s)
`ifdef STALL_COUNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] res, input logic c, input logic [4:0] rd,
                         input logic rw, input logic fu, input logic [2:0] op,
                         input logic [31:0] tgt);
        in_valid    = 1'b1;
        alu_result  = res;
        alu_carry   = c;
        rd_addr     = rd;
        reg_write   = rw;
        flag_update = fu;
        br_op       = op;
        br_target   = tgt;
    endtask

    // Single branch entry through an empty buffer with out_ready=1.
    task automatic br_case(input string tag, input logic [2:0] op, input logic [31:0] res,
                           input logic [31:0] tgt, input logic exp_taken);
        drive(res, 1'b0, 5'd2, 1'b0, 1'b0, op, tgt);
        step();
        in_valid = 1'b0;
        chk({tag, "_taken"}, br_taken, exp_taken);
        chk({tag, "_addr"}, br_addr, tgt);
        step();
    endtask

    // Scoreboard: sample handshakes mid-cycle, ahead of the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                chk("sb_nonempty", sb_q.size() != 0, 1'b1);
                if (sb_q.size() != 0) begin
                    sb_entry_t e;
                    e = sb_q.pop_front();
                    chk("sb_wb_data", wb_data, e.data);
                    chk("sb_wb_addr", wb_addr, e.addr);
                    chk("sb_wb_en", wb_en, e.we);
                end
            end
            if (flush) begin
                sb_q.delete();
            end else if (in_valid && in_ready) begin
                sb_entry_t n;
                n.data = alu_result;
                n.addr = rd_addr;
                n.we   = reg_write;
                sb_q.push_back(n);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        drive(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 3'b000, 32'h0);
        in_valid = 1'b0;

        // Reset state
        step();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_wb_en", wb_en, 1'b0);
        chk("rst_br_taken", br_taken, 1'b0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_flags", {flag_c, flag_z, flag_s}, 3'b000);
        rst_n = 1'b1;
        chk("rel_in_ready_low", in_ready, 1'b0);
        step();
        chk("rel_in_ready_high", in_ready, 1'b1);

        // Single transfer, latency 1
        out_ready = 1'b1;
        drive(32'h5, 1'b0, 5'd3, 1'b1, 1'b0, 3'b000, 32'h0);
        step();
        in_valid = 1'b0;
        chk("t1_out_valid", out_valid, 1'b1);
        chk("t1_wb_en", wb_en, 1'b1);
        chk("t1_wb_addr", wb_addr, 5'd3);
        chk("t1_wb_data", wb_data, 32'h5);
        step();
        chk("t1_drained", out_valid, 1'b0);

        // Back-to-back A, B, C with downstream stalled
        out_ready = 1'b0;
        drive(32'h11, 1'b0, 5'd8, 1'b1, 1'b0, 3'b000, 32'h0);
        step();
        drive(32'h22, 1'b0, 5'd9, 1'b1, 1'b0, 3'b000, 32'h0);
        chk("t2_ready_one", in_ready, 1'b1);
        step();
        drive(32'h33, 1'b0, 5'd10, 1'b1, 1'b0, 3'b000, 32'h0);
        chk("t2_ready_full", in_ready, 1'b0);
        step();
        chk("t2_still_full", in_ready, 1'b0);
        chk("t2_head_stable", wb_data, 32'h11);
        out_ready = 1'b1;
        step();
        chk("t2_head_b", wb_data, 32'h22);
        chk("t2_ready_after", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        chk("t2_head_c", wb_data, 32'h33);
        step();
        chk("t2_empty", out_valid, 1'b0);

        // Flag update and carry branches
        drive(32'h0, 1'b1, 5'd1, 1'b1, 1'b1, 3'b000, 32'h0);
        step();
        in_valid = 1'b0;
        chk("t3_flags_pre", {flag_c, flag_z, flag_s}, 3'b000);
        step();
        chk("t3_flags_post", {flag_c, flag_z, flag_s}, 3'b110);
        br_case("bcy", 3'b101, 32'h1, 32'h100, 1'b1);
        br_case("bncy", 3'b110, 32'h1, 32'h104, 1'b0);

        // Result-based branches
        br_case("bltz_neg", 3'b010, 32'h8000_0000, 32'h40, 1'b1);
        br_case("bltz_pos", 3'b010, 32'h7FFF_FFFF, 32'h44, 1'b0);
        br_case("rsvd", 3'b111, 32'h0, 32'h48, 1'b0);
        br_case("none", 3'b000, 32'h0, 32'h4C, 1'b0);
        br_case("bz", 3'b011, 32'h0, 32'h50, 1'b1);
        br_case("bnz", 3'b100, 32'h0, 32'h54, 1'b0);

        // Unconditional branch with link write
        drive(32'h1234, 1'b0, 5'd31, 1'b1, 1'b0, 3'b001, 32'h200);
        step();
        in_valid = 1'b0;
        chk("b_link_taken", br_taken, 1'b1);
        chk("b_link_wb_en", wb_en, 1'b1);
        step();
        chk("flags_kept", {flag_c, flag_z, flag_s}, 3'b110);

        // Flush while FULL with commit and incoming entry in the same cycle
        out_ready = 1'b0;
        drive(32'h8000_00A0, 1'b0, 5'd4, 1'b1, 1'b1, 3'b000, 32'h0);
        step();
        drive(32'h0000_00B0, 1'b1, 5'd5, 1'b1, 1'b1, 3'b000, 32'h0);
        step();
        chk("t5_full", in_ready, 1'b0);
        drive(32'h0000_00C0, 1'b0, 5'd6, 1'b1, 1'b1, 3'b000, 32'h0);
        flush     = 1'b1;
        out_ready = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("t5_empty", out_valid, 1'b0);
        chk("t5_flags_head", {flag_c, flag_z, flag_s}, 3'b001);
        step();
        chk("t5_no_ghost", out_valid, 1'b0);

        // Flush in ONE drops a same-cycle accept
        out_ready = 1'b0;
        drive(32'hD0, 1'b1, 5'd7, 1'b1, 1'b1, 3'b000, 32'h0);
        step();
        drive(32'hE0, 1'b1, 5'd7, 1'b1, 1'b1, 3'b000, 32'h0);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("t6_empty", out_valid, 1'b0);
        step();
        chk("t6_dropped", out_valid, 1'b0);
        chk("t6_flags_kept", {flag_c, flag_z, flag_s}, 3'b001);

        // Stall run then reset mid-transfer
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("t7_ready", in_ready, 1'b1);
        drive(32'hF0, 1'b0, 5'd12, 1'b1, 1'b0, 3'b000, 32'h0);
        step();
        in_valid = 1'b0;
        repeat (7) step();
        chk("t7_head_stable", wb_data, 32'hF0);
`ifdef STALL_COUNT_EN
        chk("t7_stall_7", stall_cycles, 32'd7);
`endif
        rst_n = 1'b0;
        #1;
        chk("t7_rst_out_valid", out_valid, 1'b0);
        chk("t7_rst_wb_en", wb_en, 1'b0);
        chk("t7_rst_in_ready", in_ready, 1'b0);
`ifdef STALL_COUNT_EN
        chk("t7_rst_stall", stall_cycles, 32'd0);
`endif
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("sb_drain", sb_q.size(), 0);
        chk("end_out_valid", out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
